led_level_meter: RTL and testbench

- Parametrised successor to the single-sample LED intensity driver.
- Accumulates (L²+R²)/2 over a window of 2^WIN_LOG2 valid samples and takes an iterative 16-step integer square root of the window mean, giving a true windowed RMS.
- Drives an NUM_LED-segment meter with instant attack, linear decay, peak-hold and bar/dot display modes.
- Sits after the codec/equaliser output path, on the same valid-strobed sample stream.

---
 rtl/led_level_meter.sv | 225 ++++++++++++++++++++++
 tb/tb_led_level_meter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/led_level_meter.sv
// led_level_meter: windowed-RMS LED level meter.
// Squares each valid stereo sample as (L^2+R^2)/2 and sums 2^WIN_LOG2 of them.
// A 16-step bit-serial square root of the window mean gives the RMS. The
// displayed level attacks instantly and decays linearly. A peak segment is
// held for HOLD_WIN windows. Bar or dot display is selected per cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   vld                   lft_chnnl/rght_chnnl carry a new sample
//   lft_chnnl, rght_chnnl signed 16-bit samples
//   dot_mode              0 = bar, 1 = dot display
//   rms, rms_vld          last window RMS and its one-cycle update pulse
//   level                 displayed (decayed) level
//   LED                   segment outputs
//   ovr                   sticky: a window finished while the sqrt was busy
module led_level_meter #(
   parameter int unsigned NUM_LED    = 8,
   parameter int unsigned WIN_LOG2   = 5,
   parameter logic [15:0] DECAY_STEP = 16'h0400,
   parameter int unsigned HOLD_WIN   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vld,
   input  logic [15:0]        lft_chnnl,
   input  logic [15:0]        rght_chnnl,
   input  logic               dot_mode,
   output logic [15:0]        rms,
   output logic               rms_vld,
   output logic [15:0]        level,
   output logic [NUM_LED-1:0] LED,
   output logic               ovr
);

   localparam int unsigned AccW = 31 + WIN_LOG2;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} sqrt_state_e;

   // Returns {valid, index} of the highest segment whose threshold lv reaches.
   function automatic logic [4:0] top_of(input logic [15:0] lv);
      logic [4:0] t;
      t = '0;
      for (int k = 0; k < NUM_LED; k++) begin
         if (32'(lv) >= (32'd1 << (16 - NUM_LED + k))) t = {1'b1, 4'(k)};
      end
      return t;
   endfunction

   // ---------------- square and accumulate ----------------
   logic signed [31:0] l_sq, r_sq;
   logic [31:0]        sq_sum;
   logic [30:0]        sq;
   logic [AccW-1:0]    acc_q, acc_sum;
   logic [WIN_LOG2-1:0] cnt_q;
   logic               win_done;
   logic [30:0]        mean;

   assign l_sq     = $signed(lft_chnnl) * $signed(lft_chnnl);
   assign r_sq     = $signed(rght_chnnl) * $signed(rght_chnnl);
   assign sq_sum   = $unsigned(l_sq) + $unsigned(r_sq);
   assign sq       = 31'(sq_sum >> 1);
   assign acc_sum  = acc_q + AccW'(sq);
   assign mean     = 31'(acc_sum >> WIN_LOG2);
   assign win_done = vld && (cnt_q == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (vld) begin
         if (win_done) begin
            acc_q <= '0;
            cnt_q <= '0;
         end else begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + WIN_LOG2'(1);
         end
      end
   end

   // ---------------- restoring square root ----------------
   sqrt_state_e state_q, state_d;
   logic [3:0]  step_q, step_d;
   logic [31:0] rad_q, rad_d;
   logic [17:0] rem_q, rem_d;
   logic [15:0] root_q, root_d;
   logic [15:0] rms_q, rms_d;
   logic        rms_vld_q, rms_vld_d;
   logic        ovr_q, ovr_d;
   logic [19:0] rem_t, trial;

   // Bring down the next two radicand bits; trial subtrahend is 4*root+1.
   assign rem_t = {rem_q, rad_q[31:30]};
   assign trial = {2'b00, root_q, 2'b01};

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      rad_d     = rad_q;
      rem_d     = rem_q;
      root_d    = root_q;
      rms_d     = rms_q;
      rms_vld_d = 1'b0;
      ovr_d     = ovr_q;
      unique case (state_q)
         StIdle: begin
            if (win_done) begin
               state_d = StCalc;
               rad_d   = {1'b0, mean};
               rem_d   = '0;
               root_d  = '0;
               step_d  = '0;
            end
         end
         StCalc: begin
            if (rem_t >= trial) begin
               rem_d  = 18'(rem_t - trial);
               root_d = {root_q[14:0], 1'b1};
            end else begin
               rem_d  = 18'(rem_t);
               root_d = {root_q[14:0], 1'b0};
            end
            rad_d  = {rad_q[29:0], 2'b00};
            step_d = step_q + 4'd1;
            if (step_q == 4'd15) state_d = StDone;
            if (win_done) ovr_d = 1'b1;
         end
         StDone: begin
            rms_d     = root_q;
            rms_vld_d = 1'b1;
            state_d   = StIdle;
            if (win_done) ovr_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         step_q    <= '0;
         rad_q     <= '0;
         rem_q     <= '0;
         root_q    <= '0;
         rms_q     <= '0;
         rms_vld_q <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         rad_q     <= rad_d;
         rem_q     <= rem_d;
         root_q    <= root_d;
         rms_q     <= rms_d;
         rms_vld_q <= rms_vld_d;
         ovr_q     <= ovr_d;
      end
   end

   // ---------------- level, peak hold and LED drive ----------------
   logic [15:0]        level_q, level_d, decayed;
   logic [3:0]         peak_q, peak_d;
   logic               peak_vld_q, peak_vld_d;
   logic [7:0]         hold_q, hold_d;
   logic [4:0]         top_n, top_c;
   logic [NUM_LED-1:0] led_q, led_d;

   always_comb begin
      level_d    = level_q;
      peak_d     = peak_q;
      peak_vld_d = peak_vld_q;
      hold_d     = hold_q;
      decayed    = (level_q > DECAY_STEP) ? level_q - DECAY_STEP : 16'h0000;
      if (rms_vld_q) begin
         if (rms_q >= level_q) level_d = rms_q;
         else                  level_d = (decayed > rms_q) ? decayed : rms_q;
      end
      // Peak tracking uses the top segment of the level being written.
      top_n = top_of(level_d);
      if (rms_vld_q) begin
         if (top_n[4] && (!peak_vld_q || top_n[3:0] >= peak_q)) begin
            peak_d     = top_n[3:0];
            peak_vld_d = 1'b1;
            hold_d     = 8'(HOLD_WIN);
         end else if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
         end else begin
            peak_d     = top_n[3:0];
            peak_vld_d = top_n[4];
         end
      end
   end

   always_comb begin
      top_c = top_of(level_q);
      led_d = '0;
      for (int k = 0; k < NUM_LED; k++) begin
         if (dot_mode) led_d[k] = top_c[4] && (top_c[3:0] == 4'(k));
         else          led_d[k] = 32'(level_q) >= (32'd1 << (16 - NUM_LED + k));
         if (peak_vld_q && (peak_q == 4'(k))) led_d[k] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q    <= '0;
         peak_q     <= '0;
         peak_vld_q <= 1'b0;
         hold_q     <= '0;
         led_q      <= '0;
      end else begin
         level_q    <= level_d;
         peak_q     <= peak_d;
         peak_vld_q <= peak_vld_d;
         hold_q     <= hold_d;
         led_q      <= led_d;
      end
   end

   assign rms     = rms_q;
   assign rms_vld = rms_vld_q;
   assign level   = level_q;
   assign LED     = led_q;
   assign ovr     = ovr_q;

endmodule

// File: tb/tb_led_level_meter.sv
// tb_led_level_meter: directed self-checking bench for led_level_meter.
// A second instance with a 4-sample window exercises the overrun flag.
module tb_led_level_meter;

   logic        clk;
   logic        rst_n;
   logic        vld, dot_mode;
   logic [15:0] lft, rght;
   logic [15:0] rms, level;
   logic        rms_vld, ovr;
   logic [7:0]  led;

   logic        vld2;
   logic [15:0] lft2, rght2;
   logic [15:0] rms2, level2;
   logic        rms_vld2, ovr2;
   logic [7:0]  led2;

   int checks   = 0;
   int failures = 0;

   led_level_meter #(
      .NUM_LED    (8),
      .WIN_LOG2   (5),
      .DECAY_STEP (16'h0400),
      .HOLD_WIN   (8)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vld        (vld),
      .lft_chnnl  (lft),
      .rght_chnnl (rght),
      .dot_mode   (dot_mode),
      .rms        (rms),
      .rms_vld    (rms_vld),
      .level      (level),
      .LED        (led),
      .ovr        (ovr)
   );

   led_level_meter #(
      .NUM_LED    (8),
      .WIN_LOG2   (2),
      .DECAY_STEP (16'h0400),
      .HOLD_WIN   (8)
   ) u_dut_ovr (
      .clk        (clk),
      .rst_n      (rst_n),
      .vld        (vld2),
      .lft_chnnl  (lft2),
      .rght_chnnl (rght2),
      .dot_mode   (1'b0),
      .rms        (rms2),
      .rms_vld    (rms_vld2),
      .level      (level2),
      .LED        (led2),
      .ovr        (ovr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for rms_vld; lat counts falling edges from the completing edge.
   task automatic wait_rms(output int lat);
      lat = 0;
      while (!rms_vld && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Sends one full window of identical samples, then checks the result path.
   task automatic run_window(input string tag, input logic [15:0] l, input logic [15:0] r,
                             input logic [15:0] exp_rms, input logic [15:0] exp_level,
                             input logic [7:0] exp_led);
      int lat;
      for (int i = 0; i < 32; i++) begin
         vld  = 1'b1;
         lft  = l;
         rght = r;
         @(negedge clk);
      end
      vld = 1'b0;
      wait_rms(lat);
      check({tag, "_lat"}, 16'(lat), 16'd17);
      check({tag, "_rms"}, rms, exp_rms);
      @(negedge clk);
      check({tag, "_pulse"}, {15'd0, rms_vld}, 16'd0);
      check({tag, "_level"}, level, exp_level);
      @(negedge clk);
      check({tag, "_led"}, {8'd0, led}, {8'd0, exp_led});
   endtask

   initial begin
      int lat;
      int seen;
      rst_n    = 1'b0;
      vld      = 1'b0;
      dot_mode = 1'b0;
      lft      = '0;
      rght     = '0;
      vld2     = 1'b0;
      lft2     = '0;
      rght2    = '0;
      repeat (3) @(negedge clk);
      check("rst_rms", rms, 16'h0000);
      check("rst_rms_vld", {15'd0, rms_vld}, 16'd0);
      check("rst_level", level, 16'h0000);
      check("rst_led", {8'd0, led}, 16'h0000);
      check("rst_ovr", {15'd0, ovr}, 16'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Attack from zero: bar covers segments 0..4.
      run_window("w1000", 16'h1000, 16'h1000, 16'h1000, 16'h1000, 8'h1F);
      // Silent window: one decay step, segment 4 held as peak.
      run_window("wzero", 16'h0000, 16'h0000, 16'h0000, 16'h0C00, 8'h1F);
      dot_mode = 1'b1;
      @(negedge clk);
      check("dot_led", {8'd0, led}, 16'h0018);
      dot_mode = 1'b0;
      @(negedge clk);
      check("bar_led", {8'd0, led}, 16'h001F);

      // Full-scale negative samples light all segments.
      run_window("w8000", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 8'hFF);
      // Left-only near full scale: rms below level, decay limited to one step.
      run_window("w7fff", 16'h7FFF, 16'h0000, 16'h5A81, 16'h7C00, 8'hFF);
      // Level 0x7800 reaches segment 6; peak 7 still held.
      run_window("wdec", 16'h0000, 16'h0000, 16'h0000, 16'h7800, 8'hFF);

      // Continuous silence: level decays to 0 and the hold expires.
      for (int i = 0; i < 40 * 32; i++) begin
         vld  = 1'b1;
         lft  = 16'h0000;
         rght = 16'h0000;
         @(negedge clk);
      end
      vld = 1'b0;
      repeat (25) @(negedge clk);
      check("stream_level", level, 16'h0000);
      check("stream_led", {8'd0, led}, 16'h0000);
      check("stream_rms", rms, 16'h0000);
      check("stream_ovr", {15'd0, ovr}, 16'd0);

      // Overrun: 4-sample windows back to back while the sqrt is busy.
      for (int i = 0; i < 8; i++) begin
         vld2  = 1'b1;
         lft2  = (i < 4) ? 16'h1000 : 16'h0800;
         rght2 = (i < 4) ? 16'h1000 : 16'h0800;
         @(negedge clk);
      end
      vld2 = 1'b0;
      lat  = 0;
      while (!rms_vld2 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("ovr_timeout", {15'd0, rms_vld2}, 16'd1);
      check("ovr_rms", rms2, 16'h1000);
      check("ovr_flag", {15'd0, ovr2}, 16'd1);

      // Bring level up, then reset in the middle of the next sqrt.
      run_window("w2000", 16'h2000, 16'h2000, 16'h2000, 16'h2000, 8'h3F);
      for (int i = 0; i < 32; i++) begin
         vld  = 1'b1;
         lft  = 16'h1000;
         rght = 16'h1000;
         @(negedge clk);
      end
      vld = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rms", rms, 16'h0000);
      check("mid_rst_level", level, 16'h0000);
      check("mid_rst_led", {8'd0, led}, 16'h0000);
      check("mid_rst_ovr2", {15'd0, ovr2}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rms_vld) seen++;
      end
      check("mid_rst_no_vld", 16'(seen), 16'd0);
      run_window("w0800", 16'h0800, 16'h0800, 16'h0800, 16'h0800, 8'h0F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
